uart_mmio_core: RTL and testbench



---
 rtl/uart_mmio_core.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_core.sv
// uart_mmio_core: UART peripheral behind the data path's memory-mapped UART window.
// Contains an oversample tick generator, a double-buffered 8N1 transmitter, and an
// oversampling receiver that feeds a first-word-fall-through RX FIFO.
// Optional build macro UART_PARITY_EN adds an even-parity bit on TX and checks it on RX.
//
// TX states       | meaning
// TX_IDLE         | line idle; holding byte moved to shifter, start waits for bit boundary
// TX_START        | driving the start bit (0)
// TX_DATA         | driving 8 data bits, LSB first
// TX_PARITY       | driving the even-parity bit (UART_PARITY_EN only)
// TX_STOP         | driving the stop bit (1); chains straight into the next start if holding is full
//
// RX states       | meaning
// RX_IDLE         | waiting for a high-to-low edge on the synchronised line
// RX_START        | confirming the start bit at mid-bit; a high sample is a false start
// RX_DATA         | sampling 8 data bits at mid-bit, LSB first
// RX_PARITY       | sampling and checking the parity bit (UART_PARITY_EN only)
// RX_STOP         | sampling the stop bit; push on 1, framing error on 0
module uart_mmio_core #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int RX_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       err_clr,
  input  logic       rxd,
  output logic       txd
);

  localparam int OS_RATE = BAUD * OVERSAMPLE;
  localparam int DIV_RAW = (CLK_FREQ + OS_RATE / 2) / OS_RATE;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PH_W    = $clog2(OVERSAMPLE);
  localparam int PTR_W   = $clog2(RX_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // ---------------------------------------------------------------- tick generator
  logic [DIV_W-1:0] div_cnt;
  logic             os_tick;

  assign os_tick = (div_cnt == '0);

  // Down-counter reloads on terminal count, giving a 1-cycle os_tick every DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= DIV_LOAD;
    else if (os_tick) div_cnt <= DIV_LOAD;
    else div_cnt <= div_cnt - 1'b1;
  end

  // ---------------------------------------------------------------- transmitter
  tx_state_t       tx_state;
  logic [PH_W-1:0] tx_phase;
  logic            tx_bound;
  logic [7:0]      hold;
  logic            hold_valid;
  logic [7:0]      shifter;
  logic            tx_pend;
  logic [2:0]      tx_bit;
`ifdef UART_PARITY_EN
  logic            tx_par;
`endif

  assign tx_bound = os_tick && (tx_phase == PH_LAST);
  assign tx_busy  = hold_valid;

  // Free-running TX phase; its wrap marks every bit boundary on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_phase <= '0;
    else if (os_tick) tx_phase <= (tx_phase == PH_LAST) ? '0 : tx_phase + 1'b1;
  end

  // Holding register plus shift FSM; txd is registered so reset forces it high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      txd        <= 1'b1;
      hold       <= '0;
      hold_valid <= 1'b0;
      shifter    <= '0;
      tx_pend    <= 1'b0;
      tx_bit     <= '0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      if (tx_we && !hold_valid) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_pend) begin
            if (tx_bound) begin
              tx_state <= TX_START;
              txd      <= 1'b0;
              tx_pend  <= 1'b0;
            end
          end else if (hold_valid) begin
            shifter    <= hold;
            tx_pend    <= 1'b1;
            hold_valid <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par     <= ^hold;
`endif
          end
        end
        TX_START: begin
          if (tx_bound) begin
            tx_state <= TX_DATA;
            txd      <= shifter[0];
            shifter  <= {1'b0, shifter[7:1]};
            tx_bit   <= '0;
          end
        end
        TX_DATA: begin
          if (tx_bound) begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              txd      <= tx_par;
`else
              tx_state <= TX_STOP;
              txd      <= 1'b1;
`endif
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              txd     <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bound) begin
            tx_state <= TX_STOP;
            txd      <= 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bound) begin
            if (hold_valid) begin
              // Chain the next byte directly so there is no idle gap
              tx_state   <= TX_START;
              txd        <= 1'b0;
              shifter    <= hold;
              hold_valid <= 1'b0;
`ifdef UART_PARITY_EN
              tx_par     <= ^hold;
`endif
            end else begin
              tx_state <= TX_IDLE;
              txd      <= 1'b1;
            end
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          txd      <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- receiver
  logic [1:0]      rx_sync;
  logic            rx_s;
  logic            rx_prev;
  rx_state_t       rx_state;
  logic [PH_W-1:0] rx_phase;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_sample;
  logic            rx_stop_hit;
  logic            rx_push;
  logic            ferr_set;
`ifdef UART_PARITY_EN
  logic            rx_par_ok;
`endif

  assign rx_s        = rx_sync[1];
  assign rx_sample   = os_tick && (rx_phase == PH_MID);
  assign rx_stop_hit = (rx_state == RX_STOP) && rx_sample;
`ifdef UART_PARITY_EN
  assign rx_push  = rx_stop_hit && rx_s && rx_par_ok;
  assign ferr_set = rx_stop_hit && !(rx_s && rx_par_ok);
`else
  assign rx_push  = rx_stop_hit && rx_s;
  assign ferr_set = rx_stop_hit && !rx_s;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_sync[1];
    end
  end

  // RX FSM: phase restarts on the start edge so every sample lands at mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_phase  <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
`ifdef UART_PARITY_EN
      rx_par_ok <= 1'b1;
`endif
    end else begin
      if (rx_state == RX_IDLE && rx_prev && !rx_s) rx_phase <= '0;
      else if (os_tick) rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_sample) begin
            if (rx_s) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_sample) begin
            rx_par_ok <= (rx_s == ^rx_shift);
            rx_state  <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_sample) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             ovr_set;

  assign rx_valid = (count != '0);
  assign full     = (count == CNT_FULL);
  assign pop      = rx_re && rx_valid;
  assign wr_en    = rx_push && (!full || pop);
  assign ovr_set  = rx_push && full && !pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  // Storage array; on push+pop at full the new byte lands in the slot being vacated
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_shift;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle beats err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (ferr_set) rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      if (ovr_set) rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_core.sv
// tb_uart_mmio_core: self-checking bench for uart_mmio_core at DIV=1, 16 clocks per bit.
// TX bytes are checked by a line monitor against a queue of expected bytes;
// RX bytes are checked against a queue filled as frames are driven on rxd.
`timescale 1ns/1ps
module tb_uart_mmio_core;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int DEPTH    = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_we = 1'b0;
  logic       rx_re = 1'b0;
  logic       err_clr = 1'b0;
  logic       rxd = 1'b1;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       txd;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  int         tx_starts [$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       push;
    logic       ferr;
  } rx_vec_t;

  uart_mmio_core #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .rx_re(rx_re), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .err_clr(err_clr),
    .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(posedge clk); #1 tx_data = d; tx_we = 1'b1;
    @(posedge clk); #1 tx_we = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget);
    int i = 0;
    while (tx_exp.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("tx_drain", tx_exp.size(), 0);
  endtask

  task automatic rx_bit(input logic v);
    rxd = v;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    @(posedge clk); #1;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
`ifdef UART_PARITY_EN
    rx_bit(^d);
`endif
    rx_bit(stop);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    @(negedge clk);
    check({name, "_valid"}, rx_valid, 1);
    if (rx_exp.size() == 0) begin
      n_total++;
      $display("FAIL %s: got 0x%0h, expected no byte", name, rx_data);
    end else begin
      check(name, rx_data, rx_exp.pop_front());
    end
    rx_re = 1'b1;
    @(posedge clk); #1 rx_re = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  // Line monitor: decodes each TX frame at mid-bit and scores it against tx_exp
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        tx_starts.push_back(cyc);
        repeat (OS / 2) @(negedge clk);
        check("tx_start_bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (OS) @(negedge clk);
          b[i] = txd;
        end
`ifdef UART_PARITY_EN
        repeat (OS) @(negedge clk);
        check("tx_parity_bit", txd, {31'b0, ^b});
`endif
        repeat (OS) @(negedge clk);
        check("tx_stop_bit", txd, 1);
        if (tx_exp.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected_byte: got 0x%0h, expected none", b);
        end else begin
          check("tx_byte", b, tx_exp.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rx_vec_t vecs [5];
    int n;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0};

    // Reset mid-frame must raise txd asynchronously
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tx_write(8'h00);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("tx_mid_frame_low", txd, 0);
    #2 rst = 1'b1;
    #1 check("txd_async_reset", txd, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", rx_frame_err, 0);
    check("reset_overrun", rx_overrun, 0);
    mon_en = 1'b1;

    // 0xA5 then 0x3C written mid-frame: back-to-back frames, busy high one cycle
    tx_starts.delete();
    tx_exp.push_back(8'hA5);
    tx_write(8'hA5);
    @(negedge clk); check("tx_busy_after_write", tx_busy, 1);
    @(negedge clk); check("tx_busy_one_cycle", tx_busy, 0);
    repeat (60) @(posedge clk);
    tx_exp.push_back(8'h3C);
    tx_write(8'h3C);
    @(negedge clk); check("tx_busy_held_in_frame", tx_busy, 1);
    wait_tx_drain(800);
    if (tx_starts.size() == 2)
      check("tx_back_to_back_gap", tx_starts[1] - tx_starts[0], FRAME_BITS * OS);
    else
      check("tx_frame_count_pair", tx_starts.size(), 2);

    // Writes of 0x22 and 0x33 on consecutive cycles: 0x33 hits a full holding register
    repeat (20) @(posedge clk);
    tx_starts.delete();
    tx_exp.push_back(8'h11);
    tx_write(8'h11);
    @(posedge clk); #1 tx_data = 8'h22; tx_we = 1'b1;
    tx_exp.push_back(8'h22);
    @(posedge clk); #1 tx_data = 8'h33;
    @(negedge clk); check("tx_busy_rejects_write", tx_busy, 1);
    @(posedge clk); #1 tx_we = 1'b0;
    wait_tx_drain(800);
    repeat (200) @(negedge clk);
    check("tx_frame_count_burst", tx_starts.size(), 2);

    // Table-driven RX frames, including a low stop bit
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].push) rx_exp.push_back(vecs[k].data);
      send_rx(vecs[k].data, vecs[k].stop);
      @(negedge clk);
      check("rx_valid_after_frame", rx_valid, {31'b0, vecs[k].push});
      check("rx_frame_err_after_frame", rx_frame_err, {31'b0, vecs[k].ferr});
      if (vecs[k].push) pop_check("rx_data");
      @(negedge clk);
      check("rx_valid_after_pop", rx_valid, 0);
      check("rx_data_when_empty", rx_data, 0);
      if (vecs[k].ferr) begin
        pulse_clr();
        @(negedge clk);
        check("rx_frame_err_cleared", rx_frame_err, 0);
      end
    end

    // 4-clock low glitch is a false start
    @(posedge clk); #1 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rx_glitch_no_push", rx_valid, 0);
    check("rx_glitch_no_ferr", rx_frame_err, 0);

    // Overrun: fifth byte dropped, first four kept in order
    for (int k = 1; k <= 5; k++) begin
      if (k <= DEPTH) rx_exp.push_back(8'(k));
      send_rx(8'(k), 1'b1);
    end
    @(negedge clk);
    check("rx_overrun_set", rx_overrun, 1);
    check("rx_full_valid", rx_valid, 1);
    for (int k = 0; k < DEPTH; k++) pop_check("rx_overrun_order");
    @(negedge clk);
    check("rx_empty_after_drain", rx_valid, 0);
    pulse_clr();
    @(negedge clk);
    check("rx_overrun_cleared", rx_overrun, 0);

    // Push and pop in the same cycle at full: count and order preserved
    for (int k = 0; k < DEPTH; k++) begin
      rx_exp.push_back(8'h10 + 8'(k));
      send_rx(8'h10 + 8'(k), 1'b1);
    end
    fork
      send_rx(8'h14, 1'b1);
      begin
        n = 0;
        while (n < FRAME_BITS * OS + 40 && dut.rx_push !== 1'b1) begin
          @(negedge clk);
          n++;
        end
        if (dut.rx_push === 1'b1) begin
          check("rx_head_at_pushpop", rx_data, rx_exp.pop_front());
          rx_exp.push_back(8'h14);
          rx_re = 1'b1;
          @(posedge clk); #1 rx_re = 1'b0;
        end else begin
          n_total++;
          $display("FAIL rx_push_timeout: got no push in %0d cycles, expected one", n);
        end
      end
    join
    @(negedge clk);
    check("rx_pushpop_no_overrun", rx_overrun, 0);
    for (int k = 0; k < DEPTH; k++) pop_check("rx_pushpop_order");
    @(negedge clk);
    check("rx_pushpop_count", rx_valid, 0);

    check("tx_no_pending", tx_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
